// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: picks one of N requesters, holds a registered index
// plus one-hot enable until done, request drop or hold timeout, then rearbitrates.
module rr_grant_scheduler #(
  parameter int N        = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_idx, last_nxt;
  logic [IDX_W-1:0] idx_nxt, winner, cand;
  logic [N-1:0]     onehot_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic             valid_nxt, to_nxt, found;
  logic             rel_done, rel_drop, rel_to;

  // Rotating priority search; pointer wraps naturally in IDX_W bits.
  always_comb begin
    found  = 1'b0;
    winner = last_idx;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_idx + IDX_W'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign rel_done = done;
  assign rel_drop = !req[grant_idx];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt  = state;
    valid_nxt  = grant_valid;
    idx_nxt    = grant_idx;
    onehot_nxt = grant_onehot;
    to_nxt     = 1'b0;
    cnt_nxt    = hold_cnt;
    last_nxt   = last_idx;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = GRANT;
          valid_nxt  = 1'b1;
          idx_nxt    = winner;
          onehot_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
          last_nxt   = winner;
          cnt_nxt    = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_to) begin
          state_nxt  = IDLE;
          valid_nxt  = 1'b0;
          onehot_nxt = '0;
          // Only a pure timeout is reported; a coincident done or drop wins.
          to_nxt     = rel_to && !rel_done && !rel_drop;
        end else if (hold_cnt != '1) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
      hold_cnt     <= '0;
      last_idx     <= '1;
    end else begin
      state        <= state_nxt;
      grant_valid  <= valid_nxt;
      grant_idx    <= idx_nxt;
      grant_onehot <= onehot_nxt;
      timeout      <= to_nxt;
      hold_cnt     <= cnt_nxt;
      last_idx     <= last_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count reference model of the arbiter.
module tb_rr_grant_scheduler;
  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req = '0;
  logic        done = 1'b0;
  logic        grant_valid, timeout;
  logic [4:0]  grant_idx;
  logic [31:0] grant_onehot;

  int n_cmp = 0, n_bad = 0;

  rr_grant_scheduler #(.N(32), .IDX_W(5), .MAX_HOLD(MAX_HOLD), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference: who holds the grant and for how many cycles it has been visible.
  bit m_valid = 0, m_to = 0;
  int m_idx = 0, m_last = 31, m_cycles = 0;
  wire [31:0] m_onehot = m_valid ? (32'd1 << m_idx) : 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_idx <= 0; m_last <= 31; m_cycles <= 0; m_to <= 0;
    end else if (!m_valid) begin
      int w;
      w = -1;
      for (int k = 1; k <= 32; k++)
        if (w < 0 && req[(m_last + k) % 32]) w = (m_last + k) % 32;
      m_to <= 0;
      if (w >= 0) begin
        m_valid <= 1; m_idx <= w; m_last <= w; m_cycles <= 1;
      end
    end else begin
      bit expired;
      expired = (MAX_HOLD != 0) && (m_cycles == MAX_HOLD);
      if (done || !req[m_idx] || expired) begin
        m_valid <= 0;
        m_to    <= expired && !done && req[m_idx];
      end else begin
        m_cycles <= m_cycles + 1;
        m_to     <= 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; done = 1'b0;
    repeat (3) begin
      tick;
      n_cmp++;
      if ({grant_valid, grant_idx, grant_onehot, timeout} !== 39'd0) begin
        n_bad++;
        $display("FAIL reset_hold: valid=%0b idx=%0d onehot=%h to=%0b, want all 0",
                 grant_valid, grant_idx, grant_onehot, timeout);
      end
    end
    rst_n = 1'b1;
    repeat (10) begin
      tick;
      n_cmp++;
      if ({grant_valid, grant_idx, grant_onehot, timeout} !== 39'd0 || m_valid) begin
        n_bad++;
        $display("FAIL idle_noreq: valid=%0b idx=%0d onehot=%h to=%0b, want all 0",
                 grant_valid, grant_idx, grant_onehot, timeout);
      end
    end
  endtask

  task automatic test_single;
    bit prev = 0; int dead = -1, grants = 0;
    req = 32'h0000_0004;
    for (int c = 0; c < 24; c++) begin
      done = m_valid && m_cycles == 2;
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL single_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
      if (grant_valid && !prev) begin
        grants++;
        n_cmp++;
        if (grant_idx !== 5'd2 || grant_onehot !== 32'h4 || (grants > 1 && dead != 1)) begin
          n_bad++;
          $display("FAIL single_grant: idx=%0d onehot=%h dead=%0d, want 2 00000004 1",
                   grant_idx, grant_onehot, dead);
        end
        dead = 0;
      end else if (!grant_valid && dead >= 0) dead++;
      prev = grant_valid;
    end
    n_cmp++;
    if (grants < 5) begin
      n_bad++;
      $display("FAIL single_count: grants=%0d, want >= 5", grants);
    end
    done = 0; req = '0; tick; tick;
  endtask

  task automatic test_rr_wrap;
    int order[$];
    int exp_order[6] = '{0, 1, 31, 0, 1, 31};
    bit prev = 0;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    req = 32'h8000_0003;
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      done = m_valid && m_cycles == 1;
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL wrap_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
      if (grant_valid && !prev) order.push_back(int'(grant_idx));
      prev = grant_valid;
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= order.size() || order[i] != exp_order[i]) begin
        n_bad++;
        $display("FAIL wrap_order[%0d]: got %0d, want %0d", i,
                 (i < order.size()) ? order[i] : -1, exp_order[i]);
      end
    end
    done = 0; req = '0; tick; tick;
  endtask

  task automatic test_timeout;
    int hi = 0, dead = 0, to_cnt = 0, idx2 = -1, phase = 0;
    req = 32'h0000_0100; done = 0;
    for (int c = 0; c < 60 && phase < 3; c++) begin
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL timeout_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
      if (timeout) to_cnt++;
      case (phase)
        0: if (grant_valid) begin phase = 1; hi = 1; end
        1: if (grant_valid) hi++; else begin phase = 2; dead = 1; end
        2: if (grant_valid) begin phase = 3; idx2 = int'(grant_idx); end else dead++;
        default: ;
      endcase
    end
    n_cmp++;
    if (hi != MAX_HOLD || to_cnt != 1 || dead != 1 || idx2 != 8) begin
      n_bad++;
      $display("FAIL timeout_seq: hi=%0d pulses=%0d dead=%0d regrant=%0d, want %0d 1 1 8",
               hi, to_cnt, dead, idx2, MAX_HOLD);
    end
    req = '0; tick; tick;
  endtask

  task automatic test_drop_collision;
    req = 32'h0000_0100; done = 0;
    for (int c = 0; c < 4 && !grant_valid; c++) tick;
    repeat (3) tick;
    req = '0;
    tick;
    n_cmp++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0 || grant_idx !== 5'd8 || m_valid) begin
      n_bad++;
      $display("FAIL drop_release: valid=%0b to=%0b idx=%0d, want 0 0 8", grant_valid, timeout, grant_idx);
    end
    tick;
    req = 32'h0000_0100;
    for (int c = 0; c < 4 && !grant_valid; c++) tick;
    for (int c = 0; c < 20 && grant_valid; c++) begin
      done = m_valid && m_cycles == MAX_HOLD;
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL collide_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
    end
    n_cmp++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_release: valid=%0b to=%0b, want 0 0", grant_valid, timeout);
    end
    done = 0; req = '0; tick; tick;
  endtask

  task automatic test_async_reset;
    int order[$];
    bit prev = 0;
    req = 32'h0000_0020;
    for (int c = 0; c < 4 && !grant_valid; c++) tick;
    n_cmp++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd5) begin
      n_bad++;
      $display("FAIL arst_setup: valid=%0b idx=%0d, want 1 5", grant_valid, grant_idx);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant_valid, grant_idx, grant_onehot, timeout} !== 39'd0) begin
      n_bad++;
      $display("FAIL arst_clear: valid=%0b idx=%0d onehot=%h to=%0b, want all 0",
               grant_valid, grant_idx, grant_onehot, timeout);
    end
    req = 32'h0000_0021;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12 && order.size() < 2; c++) begin
      done = m_valid;
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL arst_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
      if (grant_valid && !prev) order.push_back(int'(grant_idx));
      prev = grant_valid;
    end
    n_cmp++;
    if (order.size() < 2 || order[0] != 0 || order[1] != 5) begin
      n_bad++;
      $display("FAIL arst_order: got %0d then %0d, want 0 then 5",
               order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1);
    end
    done = 0; req = '0; tick; tick;
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) req = $urandom & $urandom;
      done = ($urandom_range(0, 9) == 0);
      tick;
      n_cmp++;
      if (grant_valid !== m_valid || grant_idx !== 5'(m_idx) || grant_onehot !== m_onehot || timeout !== m_to) begin
        n_bad++;
        $display("FAIL random_model c=%0d: valid=%0b idx=%0d onehot=%h to=%0b, want %0b %0d %h %0b",
                 c, grant_valid, grant_idx, grant_onehot, timeout, m_valid, m_idx, m_onehot, m_to);
      end
    end
    done = 0; req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_rr_wrap;
    test_timeout;
    test_drop_collision;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
